// File: rtl/seg7_pkg.sv
// Shared definitions for the seg7 scan controller: FSM states, register map, CTRL fields.
package seg7_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_SHOW  = 2'd2
  } scan_state_e;

  localparam int unsigned REG_DATA      = 0;
  localparam int unsigned REG_CTRL      = 1;
  localparam int unsigned CTRL_ON_BIT   = 0;
  localparam int unsigned CTRL_DUTY_LSB = 8;
  localparam int unsigned CTRL_DUTY_W   = 4;

  function automatic logic [31:0] ctrl_word(input logic on, input logic [3:0] duty);
    return {20'b0, duty, 7'b0, on};
  endfunction

endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// Word-addressed register bus between a host and the seg7 scan controller.
interface seg7_scan_ctrl_if;
  logic        enable;
  logic        rw;
  logic [31:0] addr;
  logic [31:0] d_in;
  logic [31:0] d_out;
  logic        ack;

  modport master (output enable, rw, addr, d_in, input d_out, ack);
  modport slave  (input enable, rw, addr, d_in, output d_out, ack);
endinterface

// File: rtl/seg7_slot_timer.sv
// Digit-slot counter: counts 0..PRESCALE-1 while run is high, strobing the end of
// the blanking window and the end of the slot.
module seg7_slot_timer #(
  parameter int unsigned PRESCALE = 1024,
  parameter int unsigned BLANK    = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic blank_done,
  output logic slot_done
);

  localparam int unsigned CW = $clog2(PRESCALE);

  logic [CW-1:0] cnt_q, cnt_d;

  assign blank_done = run && (cnt_q == CW'(BLANK - 1));
  assign slot_done  = run && (cnt_q == CW'(PRESCALE - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (!run || slot_done) cnt_d = '0;
    else                   cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed 7-segment scan controller with DATA/CTRL bus registers and frame-synchronous
// display update. Define SEG7_SCAN_DIM_EN to enable PWM dimming via the CTRL DUTY field.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int unsigned NDIGITS  = 4,
  parameter int unsigned BASE     = 0,
  parameter int unsigned PRESCALE = 1024,
  parameter int unsigned BLANK    = 8
) (
  input  logic               clk,
  input  logic               reset,
  seg7_scan_ctrl_if.slave    bus,
  output logic [3:0]         nib,
  output logic [NDIGITS-1:0] an
);

  localparam int unsigned DW = 4 * NDIGITS;
  localparam int unsigned IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

  scan_state_e        state_q, state_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [DW-1:0]      shadow_q, shadow_d;
  logic [DW-1:0]      active_q, active_d;
  logic               on_q, on_d;
  logic               ack_q, ack_d;
  logic [31:0]        dout_q, dout_d;
  logic [NDIGITS-1:0] an_q, an_d;
  logic [3:0]         duty_rd;
`ifdef SEG7_SCAN_DIM_EN
  logic [3:0]         duty_q, duty_d;
  logic [3:0]         phase_q, phase_d;
`endif

  logic hit_data, hit_ctrl, wr_data, wr_ctrl;
  logic blank_done, slot_done, run;
  logic unused_bits;

  assign hit_data    = bus.enable && (bus.addr == 32'(BASE + REG_DATA));
  assign hit_ctrl    = bus.enable && (bus.addr == 32'(BASE + REG_CTRL));
  assign wr_data     = hit_data && bus.rw;
  assign wr_ctrl     = hit_ctrl && bus.rw;
  assign unused_bits = ^bus.d_in;

`ifdef SEG7_SCAN_DIM_EN
  assign duty_rd = duty_q;
`else
  assign duty_rd = 4'h0;
`endif

  always_comb begin
    shadow_d = shadow_q;
    on_d     = on_q;
    ack_d    = hit_data || hit_ctrl;
    dout_d   = '0;
`ifdef SEG7_SCAN_DIM_EN
    duty_d   = duty_q;
    phase_d  = phase_q + 4'd1;
`endif
    if (wr_data) shadow_d = bus.d_in[DW-1:0];
    if (wr_ctrl) begin
      on_d = bus.d_in[CTRL_ON_BIT];
`ifdef SEG7_SCAN_DIM_EN
      duty_d = bus.d_in[CTRL_DUTY_LSB +: CTRL_DUTY_W];
`endif
    end
    if (hit_data && !bus.rw) dout_d = 32'(shadow_q);
    if (hit_ctrl && !bus.rw) dout_d = ctrl_word(on_q, duty_rd);
  end

  // Timer only counts while a slot is in progress and ON stays set this cycle.
  assign run = (state_q != ST_IDLE) && on_d;

  seg7_slot_timer #(
    .PRESCALE (PRESCALE),
    .BLANK    (BLANK)
  ) u_slot_timer (
    .clk        (clk),
    .reset      (reset),
    .run        (run),
    .blank_done (blank_done),
    .slot_done  (slot_done)
  );

  // Leaving IDLE is treated as a frame boundary so the first frame shows current data.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    active_d = active_q;
    if (!on_d) begin
      state_d = ST_IDLE;
      idx_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d  = ST_BLANK;
          idx_d    = '0;
          active_d = shadow_d;
        end
        ST_BLANK: if (blank_done) state_d = ST_SHOW;
        ST_SHOW: if (slot_done) begin
          state_d = ST_BLANK;
          if (idx_q == IW'(NDIGITS - 1)) begin
            idx_d    = '0;
            active_d = shadow_d;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    an_d = '1;
    if (state_d == ST_SHOW) begin
`ifdef SEG7_SCAN_DIM_EN
      if (phase_d <= duty_q) an_d[idx_d] = 1'b0;
`else
      an_d[idx_d] = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      shadow_q <= '0;
      active_q <= '0;
      on_q     <= 1'b0;
      ack_q    <= 1'b0;
      dout_q   <= '0;
      an_q     <= '1;
`ifdef SEG7_SCAN_DIM_EN
      duty_q   <= 4'hF;
      phase_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      on_q     <= on_d;
      ack_q    <= ack_d;
      dout_q   <= dout_d;
      an_q     <= an_d;
`ifdef SEG7_SCAN_DIM_EN
      duty_q   <= duty_d;
      phase_q  <= phase_d;
`endif
    end
  end

  assign bus.ack   = ack_q;
  assign bus.d_out = dout_q;
  assign an        = an_q;
  assign nib       = active_q[{idx_q, 2'b00} +: 4];

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl: register access table plus scan/frame/reset sequences.
module tb_seg7_scan_ctrl;

  localparam int unsigned BASE = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] nib;
  logic [3:0] an;

  seg7_scan_ctrl_if bus_if ();

  seg7_scan_ctrl #(
    .NDIGITS  (4),
    .BASE     (BASE),
    .PRESCALE (16),
    .BLANK    (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if),
    .nib   (nib),
    .an    (an)
  );

  always #5 clk = ~clk;

  // Reference cycle counter; its low nibble is the expected dimming phase.
  int unsigned cyc;
  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  int errors = 0;
  int checks = 0;
  int fp = 0;

`ifdef SEG7_SCAN_DIM_EN
  localparam logic DIM = 1'b1;
`else
  localparam logic DIM = 1'b0;
`endif

  typedef struct {
    logic        en;
    logic [31:0] addr;
    logic        rw;
    logic [31:0] wdata;
    logic        exp_ack;
    logic [31:0] exp_dout;
  } bus_vec_t;

  bus_vec_t vecs[10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic bus_xfer(input logic en, input logic [31:0] a, input logic w,
                          input logic [31:0] wd, output logic ack, output logic [31:0] dout);
    bus_if.enable = en;
    bus_if.addr   = a;
    bus_if.rw     = w;
    bus_if.d_in   = wd;
    tick();
    ack  = bus_if.ack;
    dout = bus_if.d_out;
    bus_if.enable = 1'b0;
    bus_if.rw     = 1'b0;
  endtask

  task automatic write_reg(input logic [31:0] a, input logic [31:0] wd);
    logic        ack;
    logic [31:0] dout;
    bus_xfer(1'b1, a, 1'b1, wd, ack, dout);
    check("wr_ack", 32'(ack), 32'd1);
    fp = (fp + 1) % 64;
  endtask

  // Check an/nib for n cycles against the frame position fp and displayed data.
  task automatic run_check(input int n, input logic [15:0] disp);
    logic [3:0] exp_an;
    logic [3:0] exp_nib;
    logic [15:0] sh;
    int d, c;
    for (int i = 0; i < n; i++) begin
      d = fp / 16;
      c = fp % 16;
      exp_an = 4'hF;
      if (c >= 2) exp_an[d] = 1'b0;
      sh = disp >> (4 * d);
      exp_nib = sh[3:0];
      check("scan_an", 32'(an), 32'(exp_an));
      check("scan_nib", 32'(nib), 32'(exp_nib));
      tick();
      fp = (fp + 1) % 64;
    end
  endtask

  initial begin
    logic        ack;
    logic [31:0] dout;

    vecs[0] = '{1'b1, 32'(BASE),       1'b1, 32'hDEAD1234, 1'b1, 32'h0};
    vecs[1] = '{1'b0, 32'(BASE),       1'b1, 32'h00009999, 1'b0, 32'h0};
    vecs[2] = '{1'b1, 32'(BASE),       1'b0, 32'h0,        1'b1, 32'h1234};
    vecs[3] = '{1'b1, 32'(BASE + 1),   1'b1, 32'h00000301, 1'b1, 32'h0};
    vecs[4] = '{1'b1, 32'(BASE + 1),   1'b0, 32'h0,        1'b1, DIM ? 32'h301 : 32'h001};
    vecs[5] = '{1'b1, 32'(BASE + 2),   1'b0, 32'h0,        1'b0, 32'h0};
    vecs[6] = '{1'b1, 32'(BASE - 1),   1'b1, 32'h0000FFFF, 1'b0, 32'h0};
    vecs[7] = '{1'b1, 32'(BASE),       1'b0, 32'h0,        1'b1, 32'h1234};
    vecs[8] = '{1'b1, 32'(BASE + 1),   1'b1, 32'h00000000, 1'b1, 32'h0};
    vecs[9] = '{1'b1, 32'(BASE + 256), 1'b0, 32'h0,        1'b0, 32'h0};

    bus_if.enable = 1'b0;
    bus_if.rw     = 1'b0;
    bus_if.addr   = '0;
    bus_if.d_in   = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_an", 32'(an), 32'hF);
    check("rst_nib", 32'(nib), 32'h0);
    check("rst_ack", 32'(bus_if.ack), 32'h0);
    check("rst_dout", bus_if.d_out, 32'h0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 10; i++) begin
      bus_xfer(vecs[i].en, vecs[i].addr, vecs[i].rw, vecs[i].wdata, ack, dout);
      check($sformatf("vec%0d_ack", i), 32'(ack), 32'(vecs[i].exp_ack));
      check($sformatf("vec%0d_dout", i), dout, vecs[i].exp_dout);
      tick();
      check($sformatf("vec%0d_ack_end", i), 32'(bus_if.ack), 32'h0);
      check($sformatf("vec%0d_dout_end", i), bus_if.d_out, 32'h0);
    end

    // Scan a full frame, then a mid-frame DATA write held until the wrap.
    write_reg(BASE + 1, 32'hF01);
    fp = 0;
    run_check(64, 16'h1234);
    run_check(20, 16'h1234);
    write_reg(BASE, 32'hABCD);
    run_check(43, 16'h1234);
    run_check(64, 16'hABCD);

    // DATA write in the frame-boundary cycle joins the frame starting there.
    run_check(63, 16'hABCD);
    write_reg(BASE, 32'h5A5A);
    check("boundary_fp", 32'(fp), 32'd0);
    run_check(64, 16'h5A5A);

    // Reset during SHOW of digit 2 with an ack pending.
    run_check(37, 16'h5A5A);
    bus_xfer(1'b1, 32'(BASE), 1'b0, 32'h0, ack, dout);
    check("pre_rst_ack", 32'(ack), 32'd1);
    check("pre_rst_dout", dout, 32'h5A5A);
    check("pre_rst_an", 32'(an), 32'hB);
    check("pre_rst_nib", 32'(nib), 32'hA);
    reset = 1'b1;
    #1;
    check("mid_rst_an", 32'(an), 32'hF);
    check("mid_rst_nib", 32'(nib), 32'h0);
    check("mid_rst_ack", 32'(bus_if.ack), 32'h0);
    check("mid_rst_dout", bus_if.d_out, 32'h0);
    tick();
    reset = 1'b0;
    tick();
    bus_xfer(1'b1, 32'(BASE), 1'b0, 32'h0, ack, dout);
    check("post_rst_data", dout, 32'h0);
    bus_xfer(1'b1, 32'(BASE + 1), 1'b0, 32'h0, ack, dout);
    check("post_rst_ctrl", dout, DIM ? 32'hF00 : 32'h0);
    repeat (4) tick();
    check("post_rst_an", 32'(an), 32'hF);

    // Clearing ON in SHOW goes idle on the next cycle.
    write_reg(BASE, 32'h1234);
    write_reg(BASE + 1, 32'hF01);
    fp = 0;
    run_check(20, 16'h1234);
    write_reg(BASE + 1, 32'h0);
    check("off_an", 32'(an), 32'hF);
    check("off_nib", 32'(nib), 32'h4);
    repeat (20) tick();
    check("off_an_hold", 32'(an), 32'hF);

`ifdef SEG7_SCAN_DIM_EN
    begin
      int lit = 0;
      logic [3:0] exp_an;
      int d, c;
      write_reg(BASE + 1, 32'h301);
      fp = 0;
      for (int i = 0; i < 64; i++) begin
        d = fp / 16;
        c = fp % 16;
        exp_an = 4'hF;
        if (c >= 2 && cyc[3:0] <= 4'd3) exp_an[d] = 1'b0;
        if (c >= 2 && an[d] == 1'b0) lit++;
        check("dim_an", 32'(an), 32'(exp_an));
        tick();
        fp = (fp + 1) % 64;
      end
      check("dim_lit_le16", 32'(lit <= 16), 32'd1);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/seg7_scan_ctrl.md
SEG7_SCAN_CTRL -- requirements
Module: seg7_scan_ctrl

Interface
REQ-001 SHALL have parameter NDIGITS, default 4, number of multiplexed digits (1..8).
REQ-002 SHALL have parameter BASE, default 0, bus word address of the DATA register; CTRL is at BASE+1.
REQ-003 SHALL have parameter PRESCALE, default 1024, clk cycles per digit slot (>= BLANK+2).
REQ-004 SHALL have parameter BLANK, default 8, dead-time cycles at the start of each slot (>= 1).
REQ-005 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port enable  input  1  bus access strobe.
REQ-008 SHALL have port rw  input  1  1 = write, 0 = read.
REQ-009 SHALL have port addr  input  32  bus word address.
REQ-010 SHALL have port d_in  input  32  write data.
REQ-011 SHALL have port d_out  output  32  read data, valid while ack = 1.
REQ-012 SHALL have port ack  output  1  one-cycle access acknowledge.
REQ-013 SHALL have port nib  output  4  hex nibble of the currently scanned digit, to the decoder.
REQ-014 SHALL have port an  output  NDIGITS  active-low digit enables.

Function
REQ-015 SHALL, on enable=1 with addr equal to BASE or BASE+1, pulse ack for exactly one cycle in the following cycle; any other addr SHALL give no ack.
REQ-016 SHALL, on a DATA write, load d_in[4*NDIGITS-1:0] into the shadow register.
REQ-017 SHALL, on a CTRL write, load bit0 (ON) and bits[11:8] (DUTY).
REQ-018 SHALL, on a read, return the shadow register (DATA) or {20'b0, DUTY, 7'b0, ON} (CTRL) on d_out with ack, zero-extended; d_out SHALL be 0 when ack=0.
REQ-019 SHALL implement FSM states IDLE, BLANK, SHOW.
REQ-020 SHALL go IDLE->BLANK when ON=1, with digit index 0 and slot counter 0.
REQ-021 SHALL spend BLANK cycles in BLANK (an all ones), then PRESCALE-BLANK cycles in SHOW (an[idx]=0, others 1).
REQ-022 SHALL, at the end of SHOW, increment idx and enter BLANK; idx SHALL wrap from NDIGITS-1 to 0.
REQ-023 SHALL, on an idx wrap to 0 (frame boundary), copy the shadow into the active register; a DATA write in the same cycle SHALL be included in the copy.
REQ-024 SHALL drive nib = active[4*idx+3:4*idx] in all states.
REQ-025 SHALL, when ON is cleared, enter IDLE on the next cycle from any state, with an all ones and idx cleared.
REQ-026 SHALL, with NDIGITS=1, keep idx at 0 and copy shadow to active at every slot end.

Reset
REQ-027 SHALL, while reset=1, force: state IDLE, idx 0, slot counter 0, shadow 0, active 0, ON 0, DUTY 4'hF, ack 0, d_out 0, nib 0, an all ones.
REQ-028 SHALL, on assertion of reset mid-slot or mid-access, abandon the slot and drop the pending ack.

Configuration
REQ-029 SHALL honour macro SEG7_SCAN_DIM_EN: when defined, a free-running 4-bit phase counter SHALL gate an[idx] in SHOW so the digit is lit only when phase <= DUTY (DUTY=15 gives full on).
REQ-030 SHALL, without SEG7_SCAN_DIM_EN, ignore DUTY writes, read DUTY as 0, and light the digit for all of SHOW.

Structure
REQ-031 SHALL place the FSM state enum, register offsets (DATA=0, CTRL=1) and CTRL bit positions in shared package seg7_pkg.
REQ-032 SHALL instantiate one sub-module, seg7_slot_timer, holding the slot counter and producing the blank_done and slot_done strobes.

Verification
REQ-033 Bench SHALL run NDIGITS=4, PRESCALE=16, BLANK=2: reset, write DATA=0x1234, write CTRL=1 -> per slot, an=4'b1111 for 2 cycles then 4'b1110 for 14 cycles with nib=4; digits 1..3 follow with nib 3,2,1.
REQ-034 Bench SHALL, mid-frame, write DATA=0xABCD -> nib keeps old values until idx wraps, then the first slot of the next frame shows nib=D.
REQ-035 Bench SHALL write DATA coincident with the frame-boundary cycle -> the new value is displayed in the frame that starts at that boundary.
REQ-036 Bench SHALL read CTRL after writing 0x301 -> ack one cycle later with d_out=0x301 (0x001 without SEG7_SCAN_DIM_EN); read of BASE+2 -> no ack.
REQ-037 Bench SHALL, with SEG7_SCAN_DIM_EN and DUTY=3, check that an[idx] is low for 4 of every 16 SHOW cycles.
REQ-038 Bench SHALL assert reset in SHOW of digit 2 -> an=4'b1111 and all registers at reset values immediately; clear ON mid-SHOW -> IDLE and an all ones on the next cycle.
